calc_req_dispatcher: RTL and testbench
======================================

// Module: calc_req_dispatcher
// PURPOSE
//  Multi-port command dispatcher for the calc pipeline, generalising the fixed 4-port Calc3 port bundle.
//  Buffers tagged commands per port, tracks outstanding tags, and issues round-robin to one execution unit.
//  Routes completions back to the owning port as a one-cycle resp/tag/data pulse.
// PARAMETERS
//  NUM_PORTS  4   number of requester ports (>=2)
//  DEPTH      4   per-port command FIFO entries (power of 2, >=2)
//  TAG_W      2   tag width; 2**TAG_W tags per port
//  CMD_W      4   command width; cmd==0 is no-op
//  REG_W      4   d1/d2/r1 register-index width
//  DATA_W     32  data width
// PORTS
//  c_clk        in   1                    clock
//  rst          in   1                    synchronous, active-high reset
//  req_cmd      in   NUM_PORTS*CMD_W      per-port command; nonzero = request
//  req_d1/d2/r1 in   NUM_PORTS*REG_W      per-port operand/result register indices
//  req_tag      in   NUM_PORTS*TAG_W      per-port tag
//  req_data     in   NUM_PORTS*DATA_W     per-port data
//  req_ready    out  NUM_PORTS            port p accepts this cycle
//  iss_valid    out  1                    issue slot holds a command
//  iss_ready    in   1                    execution unit takes it
//  iss_port     out  $clog2(NUM_PORTS)    source port
//  iss_cmd/d1/d2/r1/tag/data  out  CMD_W/REG_W x3/TAG_W/DATA_W
//  cmp_valid    in   1                    completion strobe
//  cmp_port     in   $clog2(NUM_PORTS)    completing port
//  cmp_tag      in   TAG_W                completing tag
//  cmp_resp     in   2                    1=ok 2=ovf/err 3=invalid
//  cmp_data     in   DATA_W               result
//  out_resp     out  NUM_PORTS*2          per-port response; 0 = none
//  out_tag      out  NUM_PORTS*TAG_W      per-port response tag
//  out_data     out  NUM_PORTS*DATA_W     per-port response data
//  err_spurious out  1                    sticky: completion for non-outstanding tag
// BEHAVIOUR
//  Reset: FIFOs empty, busy bitmaps clear, rr pointer=0, iss_valid=0, all iss_*=0,
//   out_resp/out_tag/out_data=0, err_spurious=0. Reset mid-operation discards queued,
//   issued and outstanding commands; completions arriving later set err_spurious.
//  req_ready[p] = !fifo_full[p] && !busy[p][req_tag[p]] (combinational, pre-update busy).
//  Enqueue when req_cmd[p]!=0 && req_ready[p]; sets busy[p][tag]. cmd!=0 while not ready: dropped, no state change.
//  Outstanding = queued or issued, not yet completed. Busy clears on cmp_valid for matching (port, tag).
//  Same-cycle completion and new request for the same tag: request stalls (ready=0) that cycle.
//  Issue register: loads when (!iss_valid || iss_ready) and any FIFO is non-empty.
//   Winner = first non-empty port at or after rr pointer (wrapping). Pop winner; rr <= winner+1 mod NUM_PORTS.
//   iss_* held stable while iss_valid && !iss_ready. Back-to-back issue with no bubble.
//   Min latency: enqueue on edge N -> iss_valid high after edge N+1.
//  Empty FIFO is never popped. Full FIFO deasserts req_ready. Push and pop in the same cycle on a full FIFO:
//   push is refused, since ready uses pre-pop state.
//  Completion: on cmp_valid, next cycle out_resp[cmp_port]=cmp_resp, out_tag/out_data=cmp_tag/cmp_data.
//   Other ports get out_resp=0. out_tag/out_data hold their last value when out_resp=0.
//   If busy[cmp_port][cmp_tag]==0: no output pulse, err_spurious<=1 until rst.
//  FIFO pointers: $clog2(DEPTH)+1 bits, wrap naturally; full = MSB differ and rest equal.
// TESTING
//  Reset, idle 10 cycles -> iss_valid=0, out_resp=0, req_ready all 1, err_spurious=0.
//  Ports 0..3 each send cmd=1 tag=0 same cycle, iss_ready=1 -> issue order ports 0,1,2,3 on consecutive cycles.
//  Port 1 sends tags 0..3 (DEPTH=4) with iss_ready=0 -> req_ready[1]=0 after 4th; tag 0 repeat stalls until its completion.
//  cmp_valid port2 tag1 resp=1 data=0x1234 -> next cycle out_resp[2]=1, out_data[2]=0x1234, others 0.
//  cmp_valid for never-issued port0 tag3 -> no out_resp pulse, err_spurious=1 until rst.
//  rst asserted with 3 queued and 1 issued -> next cycle all FIFOs empty, iss_valid=0, all tags free.

Source files
------------

// File: rtl/calc_req_dispatcher.sv
// calc_req_dispatcher: per-port tagged command FIFOs feeding one execution
// unit through a round-robin issue register, with per-port outstanding-tag
// tracking and completion routing back to the owning port.
//
// Handshakes: a request on port p is presented by req_cmd[p] != 0 and is
// taken on the edge where req_ready[p] is high. On the issue side a transfer
// happens on every edge where iss_valid and iss_ready are both high; once
// iss_valid rises, iss_* stay unchanged until that transfer occurs.
module calc_req_dispatcher #(
    parameter int NUM_PORTS = 4,
    parameter int DEPTH     = 4,
    parameter int TAG_W     = 2,
    parameter int CMD_W     = 4,
    parameter int REG_W     = 4,
    parameter int DATA_W    = 32
) (
    input  logic                          c_clk,
    input  logic                          rst,
    input  logic [NUM_PORTS*CMD_W-1:0]    req_cmd,
    input  logic [NUM_PORTS*REG_W-1:0]    req_d1,
    input  logic [NUM_PORTS*REG_W-1:0]    req_d2,
    input  logic [NUM_PORTS*REG_W-1:0]    req_r1,
    input  logic [NUM_PORTS*TAG_W-1:0]    req_tag,
    input  logic [NUM_PORTS*DATA_W-1:0]   req_data,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic                          iss_valid,
    input  logic                          iss_ready,
    output logic [$clog2(NUM_PORTS)-1:0]  iss_port,
    output logic [CMD_W-1:0]              iss_cmd,
    output logic [REG_W-1:0]              iss_d1,
    output logic [REG_W-1:0]              iss_d2,
    output logic [REG_W-1:0]              iss_r1,
    output logic [TAG_W-1:0]              iss_tag,
    output logic [DATA_W-1:0]             iss_data,
    input  logic                          cmp_valid,
    input  logic [$clog2(NUM_PORTS)-1:0]  cmp_port,
    input  logic [TAG_W-1:0]              cmp_tag,
    input  logic [1:0]                    cmp_resp,
    input  logic [DATA_W-1:0]             cmp_data,
    output logic [NUM_PORTS*2-1:0]        out_resp,
    output logic [NUM_PORTS*TAG_W-1:0]    out_tag,
    output logic [NUM_PORTS*DATA_W-1:0]   out_data,
    output logic                          err_spurious
);

    localparam int PW = $clog2(NUM_PORTS);
    localparam int AW = $clog2(DEPTH);
    localparam int NT = 2 ** TAG_W;
    localparam int EW = CMD_W + 3 * REG_W + TAG_W + DATA_W;

    logic [EW-1:0]        fifo_mem [NUM_PORTS][DEPTH];
    logic [AW:0]          wr_ptr   [NUM_PORTS];
    logic [AW:0]          rd_ptr   [NUM_PORTS];
    logic [NT-1:0]        busy     [NUM_PORTS];
    logic [EW-1:0]        entry_in [NUM_PORTS];
    logic [NT-1:0]        set_mask [NUM_PORTS];
    logic [NT-1:0]        clr_mask [NUM_PORTS];
    logic [NUM_PORTS-1:0] fifo_empty;
    logic [NUM_PORTS-1:0] fifo_full;
    logic [NUM_PORTS-1:0] push;
    logic [NUM_PORTS-1:0] pop;
    logic [PW-1:0]        rr_ptr;
    logic [PW-1:0]        winner;
    logic [PW-1:0]        cand;
    logic                 found;
    logic                 load;
    logic                 cmp_hit;
    logic [EW-1:0]        head;

    // A completion only counts when it names a real port whose tag is outstanding
    assign cmp_hit = cmp_valid
                  && ({1'b0, cmp_port} < (PW+1)'(NUM_PORTS))
                  && busy[cmp_port][cmp_tag];

    // FIFO status, request acceptance (pre-update busy/full) and busy set/clear masks
    always_comb begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            fifo_empty[p] = (wr_ptr[p] == rd_ptr[p]);
            fifo_full[p]  = (wr_ptr[p][AW] != rd_ptr[p][AW])
                         && (wr_ptr[p][AW-1:0] == rd_ptr[p][AW-1:0]);
            req_ready[p]  = !fifo_full[p] && !busy[p][req_tag[p*TAG_W +: TAG_W]];
            push[p]       = (req_cmd[p*CMD_W +: CMD_W] != '0) && req_ready[p];
            entry_in[p]   = {req_cmd[p*CMD_W +: CMD_W],
                             req_d1[p*REG_W +: REG_W],
                             req_d2[p*REG_W +: REG_W],
                             req_r1[p*REG_W +: REG_W],
                             req_tag[p*TAG_W +: TAG_W],
                             req_data[p*DATA_W +: DATA_W]};
            set_mask[p]   = push[p] ? (NT'(1) << req_tag[p*TAG_W +: TAG_W]) : '0;
            clr_mask[p]   = (cmp_hit && (int'(cmp_port) == p)) ? (NT'(1) << cmp_tag) : '0;
        end
    end

    // Round-robin search for the first non-empty FIFO at or after rr_ptr
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand = PW'((int'(rr_ptr) + i) % NUM_PORTS);
            if (!found && !fifo_empty[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        load = (!iss_valid || iss_ready) && found;
        for (int p = 0; p < NUM_PORTS; p++) begin
            pop[p] = load && (int'(winner) == p);
        end
        head = fifo_mem[winner][rd_ptr[winner][AW-1:0]];
    end

    // FIFO pointers and outstanding-tag bitmaps
    always_ff @(posedge c_clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                wr_ptr[p] <= '0;
                rd_ptr[p] <= '0;
                busy[p]   <= '0;
            end
        end else begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (push[p]) wr_ptr[p] <= wr_ptr[p] + 1'b1;
                if (pop[p])  rd_ptr[p] <= rd_ptr[p] + 1'b1;
                busy[p] <= (busy[p] | set_mask[p]) & ~clr_mask[p];
            end
        end
    end

    // FIFO storage; contents are meaningless while the pointers say empty
    always_ff @(posedge c_clk) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (push[p]) fifo_mem[p][wr_ptr[p][AW-1:0]] <= entry_in[p];
        end
    end

    // Issue register: refill whenever empty or being taken, otherwise hold
    always_ff @(posedge c_clk) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss_port  <= '0;
            rr_ptr    <= '0;
            {iss_cmd, iss_d1, iss_d2, iss_r1, iss_tag, iss_data} <= '0;
        end else if (load) begin
            iss_valid <= 1'b1;
            iss_port  <= winner;
            rr_ptr    <= (winner == PW'(NUM_PORTS - 1)) ? '0 : winner + 1'b1;
            {iss_cmd, iss_d1, iss_d2, iss_r1, iss_tag, iss_data} <= head;
        end else if (iss_ready) begin
            iss_valid <= 1'b0;
        end
    end

    // Completion routing: one-cycle response pulse; tag/data hold between pulses
    always_ff @(posedge c_clk) begin
        if (rst) begin
            out_resp     <= '0;
            out_tag      <= '0;
            out_data     <= '0;
            err_spurious <= 1'b0;
        end else begin
            out_resp <= '0;
            if (cmp_hit) begin
                out_resp[int'(cmp_port)*2 +: 2]          <= cmp_resp;
                out_tag[int'(cmp_port)*TAG_W +: TAG_W]   <= cmp_tag;
                out_data[int'(cmp_port)*DATA_W +: DATA_W] <= cmp_data;
            end else if (cmp_valid) begin
                err_spurious <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_calc_req_dispatcher.sv
// tb_calc_req_dispatcher: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based behavioural model of the dispatcher.
module tb_calc_req_dispatcher;

  localparam int NP     = 4;
  localparam int DEPTH  = 4;
  localparam int TAG_W  = 2;
  localparam int CMD_W  = 4;
  localparam int REG_W  = 4;
  localparam int DATA_W = 32;
  localparam int NT     = 2 ** TAG_W;

  typedef struct packed {
    logic [CMD_W-1:0]  cmd;
    logic [REG_W-1:0]  d1;
    logic [REG_W-1:0]  d2;
    logic [REG_W-1:0]  r1;
    logic [TAG_W-1:0]  tag;
    logic [DATA_W-1:0] data;
  } ent_t;

  // ---------------- clock / reset ----------------
  logic c_clk = 1'b0;
  logic rst   = 1'b1;
  always #5 c_clk = ~c_clk;

  logic [NP*CMD_W-1:0]  req_cmd  = '0;
  logic [NP*REG_W-1:0]  req_d1   = '0;
  logic [NP*REG_W-1:0]  req_d2   = '0;
  logic [NP*REG_W-1:0]  req_r1   = '0;
  logic [NP*TAG_W-1:0]  req_tag  = '0;
  logic [NP*DATA_W-1:0] req_data = '0;
  logic [NP-1:0]        req_ready;
  logic                 iss_valid;
  logic                 iss_ready = 1'b0;
  logic [1:0]           iss_port;
  logic [CMD_W-1:0]     iss_cmd;
  logic [REG_W-1:0]     iss_d1;
  logic [REG_W-1:0]     iss_d2;
  logic [REG_W-1:0]     iss_r1;
  logic [TAG_W-1:0]     iss_tag;
  logic [DATA_W-1:0]    iss_data;
  logic                 cmp_valid = 1'b0;
  logic [1:0]           cmp_port  = '0;
  logic [TAG_W-1:0]     cmp_tag   = '0;
  logic [1:0]           cmp_resp  = '0;
  logic [DATA_W-1:0]    cmp_data  = '0;
  logic [NP*2-1:0]      out_resp;
  logic [NP*TAG_W-1:0]  out_tag;
  logic [NP*DATA_W-1:0] out_data;
  logic                 err_spurious;

  calc_req_dispatcher #(
    .NUM_PORTS(NP), .DEPTH(DEPTH), .TAG_W(TAG_W),
    .CMD_W(CMD_W), .REG_W(REG_W), .DATA_W(DATA_W)
  ) dut (
    .c_clk(c_clk), .rst(rst),
    .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2), .req_r1(req_r1),
    .req_tag(req_tag), .req_data(req_data), .req_ready(req_ready),
    .iss_valid(iss_valid), .iss_ready(iss_ready), .iss_port(iss_port),
    .iss_cmd(iss_cmd), .iss_d1(iss_d1), .iss_d2(iss_d2), .iss_r1(iss_r1),
    .iss_tag(iss_tag), .iss_data(iss_data),
    .cmp_valid(cmp_valid), .cmp_port(cmp_port), .cmp_tag(cmp_tag),
    .cmp_resp(cmp_resp), .cmp_data(cmp_data),
    .out_resp(out_resp), .out_tag(out_tag), .out_data(out_data),
    .err_spurious(err_spurious)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  ent_t                 q_m [NP][$];
  bit                   busy_m [NP][NT];
  bit                   iss_v_m = 1'b0;
  ent_t                 iss_m = '0;
  int                   iss_port_m = 0;
  int                   rr_m = 0;
  logic [NP*2-1:0]      resp_m = '0;
  logic [NP*TAG_W-1:0]  tag_m = '0;
  logic [NP*DATA_W-1:0] data_m = '0;
  bit                   err_m = 1'b0;

  function automatic logic [NP-1:0] mdl_ready();
    logic [NP-1:0] r;
    for (int p = 0; p < NP; p++)
      r[p] = (q_m[p].size() < DEPTH) && !busy_m[p][req_tag[p*TAG_W +: TAG_W]];
    return r;
  endfunction

  // advance the model by one clock edge using the inputs currently applied
  task automatic model_step();
    logic [NP-1:0] rdy;
    int w, cp, ct, idx;
    bit hit;
    ent_t e;
    if (rst) begin
      for (int p = 0; p < NP; p++) begin
        q_m[p].delete();
        for (int t = 0; t < NT; t++) busy_m[p][t] = 1'b0;
      end
      iss_v_m = 1'b0; iss_m = '0; iss_port_m = 0; rr_m = 0;
      resp_m = '0; tag_m = '0; data_m = '0; err_m = 1'b0;
      return;
    end
    rdy = mdl_ready();
    cp  = int'(cmp_port);
    ct  = int'(cmp_tag);
    hit = cmp_valid && busy_m[cp][ct];
    resp_m = '0;
    if (hit) begin
      resp_m[cp*2 +: 2]          = cmp_resp;
      tag_m[cp*TAG_W +: TAG_W]   = cmp_tag;
      data_m[cp*DATA_W +: DATA_W] = cmp_data;
    end else if (cmp_valid) begin
      err_m = 1'b1;
    end
    if (!iss_v_m || iss_ready) begin
      w = -1;
      for (int i = 0; i < NP; i++) begin
        idx = (rr_m + i) % NP;
        if (w < 0 && q_m[idx].size() != 0) w = idx;
      end
      if (w >= 0) begin
        iss_m = q_m[w].pop_front();
        iss_port_m = w;
        iss_v_m = 1'b1;
        rr_m = (w + 1) % NP;
      end else begin
        iss_v_m = 1'b0;
      end
    end
    for (int p = 0; p < NP; p++) begin
      if (req_cmd[p*CMD_W +: CMD_W] != '0 && rdy[p]) begin
        e.cmd  = req_cmd[p*CMD_W +: CMD_W];
        e.d1   = req_d1[p*REG_W +: REG_W];
        e.d2   = req_d2[p*REG_W +: REG_W];
        e.r1   = req_r1[p*REG_W +: REG_W];
        e.tag  = req_tag[p*TAG_W +: TAG_W];
        e.data = req_data[p*DATA_W +: DATA_W];
        q_m[p].push_back(e);
        busy_m[p][e.tag] = 1'b1;
      end
    end
    if (hit) busy_m[cp][ct] = 1'b0;
  endtask

  // compare DUT against the model mid-cycle, then advance the model
  always @(negedge c_clk) begin
    if (chk_en) begin
      chk("req_ready", 128'(req_ready), 128'(mdl_ready()));
      chk("iss_valid", 128'(iss_valid), 128'(iss_v_m));
      if (iss_v_m && iss_valid) begin
        chk("iss_port", 128'(iss_port), 128'(iss_port_m));
        chk("iss_payload", 128'({iss_cmd, iss_d1, iss_d2, iss_r1, iss_tag, iss_data}), 128'(iss_m));
      end
      chk("out_resp", 128'(out_resp), 128'(resp_m));
      chk("out_tag", 128'(out_tag), 128'(tag_m));
      chk("out_data", 128'(out_data), 128'(data_m));
      chk("err_spurious", 128'(err_spurious), 128'(err_m));
    end
    model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge c_clk);
    #1;
  endtask

  task automatic set_req(int p, logic [CMD_W-1:0] cmd, logic [TAG_W-1:0] tag, logic [DATA_W-1:0] data);
    req_cmd[p*CMD_W +: CMD_W]    = cmd;
    req_tag[p*TAG_W +: TAG_W]    = tag;
    req_data[p*DATA_W +: DATA_W] = data;
    req_d1[p*REG_W +: REG_W]     = REG_W'($urandom_range(0, 15));
    req_d2[p*REG_W +: REG_W]     = REG_W'($urandom_range(0, 15));
    req_r1[p*REG_W +: REG_W]     = REG_W'($urandom_range(0, 15));
  endtask

  task automatic set_cmp(bit v, int p, int t, int r, logic [DATA_W-1:0] d);
    cmp_valid = v;
    cmp_port  = 2'(p);
    cmp_tag   = TAG_W'(t);
    cmp_resp  = 2'(r);
    cmp_data  = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_cmd = '0;
    set_cmp(0, 0, 0, 0, '0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int pick;
    int cand_list[$];

    // idle after reset
    do_reset();
    chk_en = 1'b1;
    iss_ready = 1'b1;
    repeat (10) tick();
    chk("idle_iss_valid", 128'(iss_valid), 128'd0);
    chk("idle_out_resp", 128'(out_resp), 128'd0);
    chk("idle_req_ready", 128'(req_ready), 128'hf);
    chk("idle_err", 128'(err_spurious), 128'd0);
    chk("idle_iss_fields", 128'({iss_port, iss_cmd, iss_tag, iss_data}), 128'd0);
    chk("idle_out_tagdata", 128'({out_tag, out_data}), 128'd0);

    // four ports at once -> issued 0,1,2,3 back to back
    for (int p = 0; p < NP; p++) set_req(p, 4'd1, 2'd0, 32'(p + 100));
    tick();
    req_cmd = '0;
    for (int k = 0; k < NP; k++) begin
      tick();
      chk("rr_valid", 128'(iss_valid), 128'd1);
      chk("rr_port", 128'(iss_port), 128'(k));
      chk("rr_data", 128'(iss_data), 128'(k + 100));
    end
    tick();
    chk("rr_drained", 128'(iss_valid), 128'd0);

    // port 1 exhausts its tags; tag 0 repeat stalls until completed
    do_reset();
    iss_ready = 1'b0;
    for (int t = 0; t < NT; t++) begin
      set_req(1, 4'd2, 2'(t), 32'(t));
      tick();
    end
    set_req(1, 4'd2, 2'd0, 32'hAA);
    #1;
    chk("tags_full_ready", 128'(req_ready[1]), 128'd0);
    tick();
    tick();
    set_cmp(1, 1, 0, 1, 32'h55);
    #1;
    chk("same_cycle_stall", 128'(req_ready[1]), 128'd0);
    tick();
    set_cmp(0, 0, 0, 0, '0);
    #1;
    chk("tag_freed_ready", 128'(req_ready[1]), 128'd1);
    tick();
    req_cmd = '0;
    set_req(1, 4'd0, 2'd1, 32'h0);
    #1;
    chk("fifo_full_ready", 128'(req_ready[1]), 128'd0);

    // completion routed to port 2
    do_reset();
    iss_ready = 1'b1;
    set_req(2, 4'd3, 2'd1, 32'hBEEF);
    tick();
    req_cmd = '0;
    tick();
    set_cmp(1, 2, 1, 1, 32'h1234);
    tick();
    set_cmp(0, 0, 0, 0, '0);
    chk("cmp_out_resp", 128'(out_resp), 128'h10);
    chk("cmp_out_data", 128'(out_data[2*DATA_W +: DATA_W]), 128'h1234);
    chk("cmp_out_tag", 128'(out_tag[2*TAG_W +: TAG_W]), 128'd1);
    tick();
    chk("cmp_pulse_end", 128'(out_resp), 128'd0);
    chk("cmp_data_hold", 128'(out_data[2*DATA_W +: DATA_W]), 128'h1234);

    // spurious completion
    set_cmp(1, 0, 3, 1, 32'h9999);
    tick();
    set_cmp(0, 0, 0, 0, '0);
    chk("spur_no_pulse", 128'(out_resp), 128'd0);
    chk("spur_err", 128'(err_spurious), 128'd1);
    repeat (3) tick();
    chk("spur_sticky", 128'(err_spurious), 128'd1);

    // reset with 3 queued and 1 issued
    do_reset();
    iss_ready = 1'b0;
    for (int p = 0; p < NP; p++) set_req(p, 4'd5, 2'd0, 32'(p));
    tick();
    req_cmd = '0;
    tick();
    chk("pre_rst_issued", 128'(iss_valid), 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_iss_valid", 128'(iss_valid), 128'd0);
    chk("rst_ready", 128'(req_ready), 128'hf);
    iss_ready = 1'b1;
    tick();
    tick();
    chk("rst_fifos_empty", 128'(iss_valid), 128'd0);
    set_cmp(1, 1, 0, 1, 32'h1);
    tick();
    set_cmp(0, 0, 0, 0, '0);
    chk("rst_late_cmp_err", 128'(err_spurious), 128'd1);
    chk("rst_late_cmp_resp", 128'(out_resp), 128'd0);

    // randomized traffic
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if ($urandom_range(0, 2) == 0)
          set_req(p, CMD_W'($urandom_range(1, 15)), TAG_W'($urandom_range(0, NT - 1)), $urandom);
        else
          set_req(p, '0, TAG_W'($urandom_range(0, NT - 1)), $urandom);
      end
      iss_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 4) begin
        cand_list.delete();
        for (int p = 0; p < NP; p++)
          for (int t = 0; t < NT; t++)
            if (busy_m[p][t]) cand_list.push_back(p * NT + t);
        if (cand_list.size() > 0 && $urandom_range(0, 29) != 0)
          pick = cand_list[$urandom_range(0, cand_list.size() - 1)];
        else
          pick = int'($urandom_range(0, NP * NT - 1));
        set_cmp(1, pick / NT, pick % NT, int'($urandom_range(0, 3)), $urandom);
      end else begin
        set_cmp(0, 0, 0, 0, '0);
      end
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;
    req_cmd = '0;
    set_cmp(0, 0, 0, 0, '0);
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
